// File: rtl/ltc2308_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ltc2308_pkg
// Brief    : Shared config-word layout, state encoding and channel decode for
//            the LTC2308 serial ADC interface (master and responder).
// Revision : 1.0
// ============================================================================
package ltc2308_pkg;

    localparam int SD_BIT  = 5;
    localparam int OS_BIT  = 4;
    localparam int S1_BIT  = 3;
    localparam int S0_BIT  = 2;
    localparam int UNI_BIT = 1;
    localparam int SLP_BIT = 0;

    localparam logic [5:0] CFG_RESET = 6'b100010;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Single-ended channel index is {S1, S0, O/S}, matching the part's mux table.
    function automatic logic [2:0] cfg_to_channel(input logic [5:0] cfg);
        return {cfg[S1_BIT], cfg[S0_BIT], cfg[OS_BIT]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ltc2308_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Multi-flop synchronizer with registered rise/fall edge detection.
// Revision : 1.0
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to low so a line already low after reset never reads as a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : ltc2308_responder
// Brief    : Slave-side LTC2308 model: decodes the DIN config word and returns
//            per-channel samples on DOUT with a one-frame pipeline.
// Revision : 1.0
// ============================================================================
module ltc2308_responder
    import ltc2308_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 12,
    parameter int CFG_BITS    = 6
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ADC_SCLK,
    input  logic                 ADC_CS_N,
    input  logic                 ADC_DIN,
    output logic                 ADC_DOUT,
    input  logic [DATA_BITS-1:0] CH0,
    input  logic [DATA_BITS-1:0] CH1,
    input  logic [DATA_BITS-1:0] CH2,
    input  logic [DATA_BITS-1:0] CH3,
    input  logic [DATA_BITS-1:0] CH4,
    input  logic [DATA_BITS-1:0] CH5,
    input  logic [DATA_BITS-1:0] CH6,
    input  logic [DATA_BITS-1:0] CH7,
    output logic [CFG_BITS-1:0]  CFG_WORD,
    output logic                 CFG_VALID,
    output logic                 FRAME_ERR,
    output logic [15:0]          FRAME_CNT
);

    localparam logic [3:0] c_CFG_CNT = 4'(CFG_BITS);
    localparam logic [3:0] c_CNT_MAX = 4'hF;

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level,   w_cs_rise,   w_cs_fall;
    logic w_din,        w_din_rise,  w_din_fall;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(CLOCK), .rst(RESET), .i_din(ADC_SCLK),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLOCK), .rst(RESET), .i_din(ADC_CS_N),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk(CLOCK), .rst(RESET), .i_din(ADC_DIN),
        .o_level(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall)
    );

    assign w_unused = ^{w_sclk_level, w_cs_level, w_din_rise, w_din_fall};

    state_t                r_state;
    logic                  r_dout;
    logic [DATA_BITS-1:0]  r_sr;
    logic [CFG_BITS-1:0]   r_cfg_sr;
    logic [3:0]            r_bit_cnt;
    logic [CFG_BITS-1:0]   r_cfg_word;
    logic [DATA_BITS-1:0]  r_sample_q;
    logic                  r_cfg_valid;
    logic                  r_frame_err;
    logic [15:0]           r_frame_cnt;
    logic                  r_latch;
    logic [DATA_BITS-1:0]  w_ch_val;
    logic [DATA_BITS-1:0]  w_sample_sel;

    always_comb begin
        w_ch_val = CH0;
        case (cfg_to_channel(r_cfg_word))
            3'd0:    w_ch_val = CH0;
            3'd1:    w_ch_val = CH1;
            3'd2:    w_ch_val = CH2;
            3'd3:    w_ch_val = CH3;
            3'd4:    w_ch_val = CH4;
            3'd5:    w_ch_val = CH5;
            3'd6:    w_ch_val = CH6;
            default: w_ch_val = CH7;
        endcase
        w_sample_sel = r_cfg_word[SD_BIT] ? w_ch_val : '0;
    end

    // The sample latches one cycle after frame end so it sees the freshly accepted word.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_dout      <= 1'b0;
            r_sr        <= '0;
            r_cfg_sr    <= '0;
            r_bit_cnt   <= '0;
            r_cfg_word  <= CFG_RESET;
            r_sample_q  <= '0;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
            r_latch     <= 1'b0;
        end else begin
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_latch     <= 1'b0;
            if (r_latch) begin
                r_sample_q <= w_sample_sel;
            end
            case (r_state)
                IDLE: begin
                    r_dout <= 1'b0;
                    if (w_cs_fall) begin
                        r_state   <= SHIFT;
                        r_sr      <= r_sample_q;
                        r_dout    <= r_sample_q[DATA_BITS-1];
                        r_bit_cnt <= '0;
                        r_cfg_sr  <= '0;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_dout      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_latch     <= 1'b1;
                        if (r_bit_cnt >= c_CFG_CNT) begin
                            r_cfg_word  <= r_cfg_sr;
                            r_cfg_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        if (r_bit_cnt < c_CFG_CNT) begin
                            r_cfg_sr <= {r_cfg_sr[CFG_BITS-2:0], w_din};
                        end
                        if (r_bit_cnt != c_CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (w_sclk_fall) begin
                        r_sr   <= {r_sr[DATA_BITS-2:0], 1'b0};
                        r_dout <= r_sr[DATA_BITS-2];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ADC_DOUT  = r_dout;
    assign CFG_WORD  = r_cfg_word;
    assign CFG_VALID = r_cfg_valid;
    assign FRAME_ERR = r_frame_err;
    assign FRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc2308_responder
// Brief    : Directed/randomized frames against a behavioural LTC2308 model.
// Revision : 1.0
// ============================================================================
module tb_ltc2308_responder;

    logic        CLOCK    = 1'b0;
    logic        RESET    = 1'b1;
    logic        ADC_SCLK = 1'b0;
    logic        ADC_CS_N = 1'b1;
    logic        ADC_DIN  = 1'b0;
    logic        ADC_DOUT;
    logic [11:0] ch [8];
    logic [5:0]  CFG_WORD;
    logic        CFG_VALID;
    logic        FRAME_ERR;
    logic [15:0] FRAME_CNT;

    int checks = 0;
    int errors = 0;

    logic [5:0]  m_cfg;
    logic [11:0] m_sample;
    logic [15:0] m_cnt;

    ltc2308_responder dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N), .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT),
        .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
        .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
        .CFG_WORD(CFG_WORD), .CFG_VALID(CFG_VALID), .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
    );

    always #10 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: single-ended picks CH[{S1,S0,O/S}], differential returns zero.
    function automatic logic [11:0] ref_sample(input logic [5:0] cfg);
        int idx;
        if (!cfg[5]) return 12'h000;
        idx = (cfg[3] ? 4 : 0) + (cfg[2] ? 2 : 0) + (cfg[4] ? 1 : 0);
        return ch[idx];
    endfunction

    task automatic wcyc(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    task automatic model_reset();
        m_cfg    = 6'b100010;
        m_sample = 12'h000;
        m_cnt    = 16'd0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        wcyc(3);
        RESET = 1'b0;
        model_reset();
        wcyc(6);
    endtask

    task automatic sclk_bit(input logic d, output logic q);
        ADC_DIN = d;
        wcyc(6);
        q = ADC_DOUT;
        ADC_SCLK = 1'b1;
        wcyc(6);
        ADC_SCLK = 1'b0;
    endtask

    task automatic run_frame(input logic [5:0] cfg, input int n, input string tag);
        logic [15:0] cap;
        logic [15:0] expv;
        logic        b;
        logic        d;
        int          nv;
        int          ne;
        ADC_CS_N = 1'b0;
        wcyc(6);
        cap  = '0;
        expv = '0;
        for (int i = 0; i < n; i++) begin
            d = (i < 6) ? cfg[5-i] : 1'($urandom);
            sclk_bit(d, b);
            cap  = {cap[14:0], b};
            expv = {expv[14:0], (i < 12) ? m_sample[11-i] : 1'b0};
        end
        wcyc(6);
        ADC_CS_N = 1'b1;
        nv = 0;
        ne = 0;
        for (int k = 0; k < 8; k++) begin
            wcyc(1);
            nv += int'(CFG_VALID);
            ne += int'(FRAME_ERR);
        end
        m_cnt = m_cnt + 16'd1;
        if (n >= 6) m_cfg = cfg;
        m_sample = ref_sample(m_cfg);
        check({tag, "_data"},  32'(cap),       32'(expv));
        check({tag, "_valid"}, 32'(nv),        (n >= 6) ? 32'd1 : 32'd0);
        check({tag, "_err"},   32'(ne),        (n < 6)  ? 32'd1 : 32'd0);
        check({tag, "_cfg"},   32'(CFG_WORD),  32'(m_cfg));
        check({tag, "_cnt"},   32'(FRAME_CNT), 32'(m_cnt));
        check({tag, "_dout"},  32'(ADC_DOUT),  32'd0);
        wcyc(4);
    endtask

    initial begin
        logic [5:0] cfg;
        logic       b;
        int         nv;
        int         ne;

        for (int i = 0; i < 8; i++) ch[i] = 12'($urandom);
        model_reset();
        do_reset();
        check("reset_dout",  32'(ADC_DOUT),  32'd0);
        check("reset_cfg",   32'(CFG_WORD),  32'h22);
        check("reset_valid", 32'(CFG_VALID), 32'd0);
        check("reset_err",   32'(FRAME_ERR), 32'd0);
        check("reset_cnt",   32'(FRAME_CNT), 32'd0);

        ch[0] = 12'hABC;
        run_frame(6'b110010, 12, "rst1");
        run_frame(6'b100010, 12, "rst2");

        do_reset();
        for (int n = 0; n < 8; n++) ch[n] = 12'(12'h100 * n + n);
        for (int n = 0; n < 8; n++) begin
            cfg = {1'b1, 1'(n & 1), 1'((n >> 2) & 1), 1'((n >> 1) & 1), 1'b1, 1'b0};
            run_frame(cfg, 12, $sformatf("sweep%0d", n));
        end
        run_frame(6'b100010, 12, "sweep_end");
        check("sweep_total", 32'(FRAME_CNT), 32'd9);

        run_frame(6'($urandom), 3, "short");
        run_frame(6'b110110, 12, "after_short");

        run_frame(6'b000010, 12, "diff");
        run_frame(6'b101010, 12, "after_diff");

        run_frame(6'b111110, 16, "over");
        run_frame(6'b100000, 12, "after_over");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) ch[i] = 12'($urandom);
            run_frame(6'($urandom), int'($urandom_range(0, 16)), $sformatf("rand%0d", r));
        end

        // Reset in the middle of a frame, CS_N held low throughout.
        ADC_CS_N = 1'b0;
        wcyc(6);
        for (int i = 0; i < 7; i++) sclk_bit(1'($urandom), b);
        RESET = 1'b1;
        wcyc(3);
        RESET = 1'b0;
        model_reset();
        wcyc(6);
        check("mid_dout", 32'(ADC_DOUT),  32'd0);
        check("mid_cnt",  32'(FRAME_CNT), 32'd0);
        check("mid_cfg",  32'(CFG_WORD),  32'h22);
        for (int i = 0; i < 8; i++) begin
            sclk_bit(1'b1, b);
            check($sformatf("mid_idle_dout%0d", i), 32'(b), 32'd0);
        end
        ADC_CS_N = 1'b1;
        nv = 0;
        ne = 0;
        for (int k = 0; k < 8; k++) begin
            wcyc(1);
            nv += int'(CFG_VALID);
            ne += int'(FRAME_ERR);
        end
        check("mid_no_valid", 32'(nv), 32'd0);
        check("mid_no_err",   32'(ne), 32'd0);
        check("mid_cnt2",     32'(FRAME_CNT), 32'd0);
        wcyc(6);
        ch[1] = 12'h5A5;
        run_frame(6'b110010, 12, "post_rst");
        run_frame(6'b100010, 12, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
